// File: rtl/uart_tx_sequencer.sv
// Transmit control FSM for the UART/IrDA datapath: baud timing plus the load,
// shift and clear strobes for the frame shift register and bit counter.
module uart_tx_sequencer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic tx_start,
    input  logic bits_done,
    output logic load,
    output logic reset_bits,
    output logic shift,
    output logic busy,
    output logic tx_done,
    output logic overrun
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BIT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] baud_next;
    logic             pending;
    logic             pending_next;
    logic             overrun_next;
    logic             start_q;
    logic             start_edge;
    logic             baud_tick;

    // While a frame runs, a request level that is still held from the one being
    // served is not a new request; only a fresh rising edge claims the slot.
    assign start_edge = tx_start & ~start_q;
    assign baud_tick  = (baud_cnt == BAUD_LAST);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
        state_next   = state;
        baud_next    = '0;
        pending_next = pending;
        overrun_next = 1'b0;
        load         = 1'b0;
        reset_bits   = 1'b0;
        shift        = 1'b0;
        busy         = 1'b0;
        tx_done      = 1'b0;

        case (state)
            IDLE: begin
                if (tx_start || pending) state_next = LOAD;
            end
            LOAD: begin
                load       = 1'b1;
                reset_bits = 1'b1;
                busy       = 1'b1;
                state_next = BIT;
            end
            BIT: begin
                busy      = 1'b1;
                baud_next = baud_tick ? '0 : baud_cnt + CNT_W'(1);
                if (bits_done) begin
                    state_next = DONE;
                end else begin
                    shift = baud_tick;
                end
            end
            DONE: begin
                tx_done    = 1'b1;
                state_next = (tx_start || pending) ? LOAD : IDLE;
            end
            default: state_next = IDLE;
        endcase

        if ((state == LOAD || state == BIT) && start_edge) begin
            if (pending) overrun_next = 1'b1;
            else         pending_next = 1'b1;
        end

        // LOAD is only ever entered from IDLE or DONE, which consume the slot.
        if (state_next == LOAD) pending_next = 1'b0;
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            pending  <= 1'b0;
            start_q  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            pending  <= pending_next;
            start_q  <= tx_start;
            overrun  <= overrun_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench for uart_tx_sequencer: one instance at 16 clocks/bit, one at
// the 2 clocks/bit corner, each closed by a behavioural 11-bit counter.
module tb_uart_tx_sequencer;

    localparam int C  = 16;
    localparam int C2 = 2;

    localparam logic [4:0] M_LOAD  = 5'b00011;  // load + reset_bits
    localparam logic [4:0] M_SHIFT = 5'b00100;
    localparam logic [4:0] M_DONE  = 5'b01000;
    localparam logic [4:0] M_OVR   = 5'b10000;

    typedef struct packed {
        int         inst;
        int         cyc;
        logic [4:0] mask;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic mon_en = 1'b0;
    logic force_bd = 1'b0;

    logic tx_start_a = 1'b0, tx_start_b = 1'b0;
    logic bits_done_a, bits_done_b;
    logic load_a, reset_bits_a, shift_a, busy_a, tx_done_a, overrun_a;
    logic load_b, reset_bits_b, shift_b, busy_b, tx_done_b, overrun_b;
    logic [4:0] mask_a, mask_b;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   bc_a = 0, bc_b = 0;
    ev_t  exp_q[$];

    uart_tx_sequencer #(.CLKS_PER_BIT(C)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .tx_start   (tx_start_a),
        .bits_done  (bits_done_a),
        .load       (load_a),
        .reset_bits (reset_bits_a),
        .shift      (shift_a),
        .busy       (busy_a),
        .tx_done    (tx_done_a),
        .overrun    (overrun_a)
    );

    uart_tx_sequencer #(.CLKS_PER_BIT(C2)) u_dut_c2 (
        .clock      (clock),
        .reset      (reset),
        .tx_start   (tx_start_b),
        .bits_done  (bits_done_b),
        .load       (load_b),
        .reset_bits (reset_bits_b),
        .shift      (shift_b),
        .busy       (busy_b),
        .tx_done    (tx_done_b),
        .overrun    (overrun_b)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Bit counters that the sequencer drives in the real datapath.
    always @(posedge clock) begin
        if (reset || reset_bits_a) bc_a <= 0;
        else if (shift_a)          bc_a <= bc_a + 1;
        if (reset || reset_bits_b) bc_b <= 0;
        else if (shift_b)          bc_b <= bc_b + 1;
    end

    assign bits_done_a = (bc_a == 11) || force_bd;
    assign bits_done_b = (bc_b == 11);
    assign mask_a = {overrun_a, tx_done_a, shift_a, reset_bits_a, load_a};
    assign mask_b = {overrun_b, tx_done_b, shift_b, reset_bits_b, load_b};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Keeps the queue ordered by cycle, then instance; same-slot events merge.
    task automatic add_ev(input int inst, input int c, input logic [4:0] m);
        int  i;
        ev_t e;
        i = 0;
        while (i < exp_q.size() &&
               (exp_q[i].cyc < c || (exp_q[i].cyc == c && exp_q[i].inst < inst))) i++;
        if (i < exp_q.size() && exp_q[i].cyc == c && exp_q[i].inst == inst) begin
            e = exp_q[i];
            e.mask = e.mask | m;
            exp_q[i] = e;
        end else begin
            e.inst = inst;
            e.cyc  = c;
            e.mask = m;
            exp_q.insert(i, e);
        end
    endtask

    task automatic add_frame(input int inst, input int load_cyc, input int cper);
        add_ev(inst, load_cyc, M_LOAD);
        for (int k = 1; k <= 11; k++) add_ev(inst, load_cyc + k * cper, M_SHIFT);
        add_ev(inst, load_cyc + 11 * cper + 2, M_DONE);
    endtask

    task automatic drop_after(input int inst, input int c);
        ev_t keep[$];
        foreach (exp_q[i])
            if (!(exp_q[i].inst == inst && exp_q[i].cyc > c)) keep.push_back(exp_q[i]);
        exp_q = keep;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic pulse_a();
        tx_start_a = 1'b1;
        @(negedge clock);
        tx_start_a = 1'b0;
    endtask

    always @(negedge clock) begin : monitor
        logic [4:0] m;
        ev_t        e;
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check("missed_event", 32'd0, 32'(exp_q[0].mask));
                void'(exp_q.pop_front());
            end
            for (int inst = 0; inst < 2; inst++) begin
                m = (inst == 0) ? mask_a : mask_b;
                if (m != 5'd0) begin
                    if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].inst == inst) begin
                        e = exp_q.pop_front();
                        check((inst == 0) ? "event_a" : "event_b", 32'(m), 32'(e.mask));
                    end else begin
                        check("unexpected_event", 32'(m), 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        int t0;
        repeat (3) @(negedge clock);
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clock);
        check("rst_outs_a", 32'(mask_a), 32'd0);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_outs_b", 32'(mask_b), 32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);

        // Single frame.
        t0 = cyc;
        add_frame(0, t0 + 1, C);
        pulse_a();
        check("single_busy_load", 32'(busy_a), 32'd1);
        wait_to(t0 + 178);
        check("single_busy_last", 32'(busy_a), 32'd1);
        wait_to(t0 + 179);
        check("single_busy_done", 32'(busy_a), 32'd0);
        wait_to(t0 + 190);

        // Held request: back-to-back frames, no IDLE gap, no overrun.
        t0 = cyc;
        tx_start_a = 1'b1;
        add_frame(0, t0 + 1, C);
        add_frame(0, t0 + 180, C);
        add_frame(0, t0 + 359, C);
        wait_to(t0 + 179);
        check("b2b_busy_done", 32'(busy_a), 32'd0);
        wait_to(t0 + 180);
        check("b2b_busy_load", 32'(busy_a), 32'd1);
        wait_to(t0 + 359);
        tx_start_a = 1'b0;
        wait_to(t0 + 545);

        // Pending slot and overrun.
        t0 = cyc;
        add_frame(0, t0 + 1, C);
        pulse_a();
        wait_to(t0 + 50);
        pulse_a();
        wait_to(t0 + 60);
        add_ev(0, t0 + 61, M_OVR);
        pulse_a();
        add_frame(0, t0 + 180, C);
        wait_to(t0 + 370);

        // Mid-frame reset drops the frame and the pending request.
        t0 = cyc;
        add_frame(0, t0 + 1, C);
        pulse_a();
        wait_to(t0 + 50);
        pulse_a();
        wait_to(t0 + 100);
        reset = 1'b1;
        drop_after(0, t0 + 100);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("abort_outs", 32'(mask_a), 32'd0);
            check("abort_busy", 32'(busy_a), 32'd0);
            @(negedge clock);
        end
        add_frame(0, t0 + 106, C);
        pulse_a();
        wait_to(t0 + 106 + 185);

        // bits_done high in IDLE without a request is ignored.
        force_bd = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("idle_bd_busy", 32'(busy_a), 32'd0);
        end
        force_bd = 1'b0;

        // Two clocks per bit corner.
        t0 = cyc;
        add_frame(1, t0 + 1, C2);
        tx_start_b = 1'b1;
        @(negedge clock);
        tx_start_b = 1'b0;
        wait_to(t0 + 24);
        check("c2_busy_last", 32'(busy_b), 32'd1);
        wait_to(t0 + 25);
        check("c2_busy_done", 32'(busy_b), 32'd0);
        wait_to(t0 + 40);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
